// File: rtl/movegen_pkg.sv
// Shared types for the move-generator stack datapath.
package movegen_pkg;

  localparam int MOVE_W = 10;

  typedef logic [MOVE_W-1:0] move_t;

  localparam move_t MOVE_NONE = '0;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

endpackage

// File: rtl/movegen_find_first.sv
// Combinational lowest-set-bit finder shared by the movegen drain blocks.
module movegen_find_first #(
  parameter int DEPTH = 16,
  parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [DEPTH-1:0] mask,
  output logic [IW-1:0]    index,
  output logic             any
);

  // Scanning high to low means the last hit written is the lowest set index.
  always_comb begin
    index = '0;
    any   = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        index = i[IW-1:0];
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/movegen_stack_reader.sv
// Snapshots the piece stack on capture and streams its non-zero slots,
// top of stack first, one per cycle over a valid/ready handshake.
module movegen_stack_reader
  import movegen_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = MOVE_W,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   capture,
  input  logic [DEPTH*WIDTH-1:0] in_slots,
  input  logic                   flush,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic [CW-1:0]          count,
  output logic                   dropped
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  drain_state_t     state_reg;
  logic [WIDTH-1:0] snap_reg [DEPTH];
  logic [DEPTH-1:0] mask_reg;
  logic [CW-1:0]    count_reg;
  logic             done_reg;
  logic             dropped_reg;

  logic [WIDTH-1:0] slot_in [DEPTH];
  logic [DEPTH-1:0] cap_mask;
  logic [IW-1:0]    ff_index;
  logic             ff_any;
  logic [DEPTH-1:0] clr_mask;
  logic [DEPTH-1:0] mask_next;
  logic             handshake;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    assign slot_in[gi]  = in_slots[gi*WIDTH +: WIDTH];
    assign cap_mask[gi] = |in_slots[gi*WIDTH +: WIDTH];
  end

  movegen_find_first #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_find_first (
    .mask  (mask_reg),
    .index (ff_index),
    .any   (ff_any)
  );

  assign busy      = (state_reg == DRAIN);
  assign out_valid = busy;
  assign out_data  = (busy && ff_any) ? snap_reg[ff_index] : '0;
  assign handshake = out_valid && out_ready;
  assign done      = done_reg;
  assign dropped   = dropped_reg;
  assign count     = count_reg;

  always_comb begin
    clr_mask           = '0;
    clr_mask[ff_index] = 1'b1;
    mask_next          = mask_reg & ~clr_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      mask_reg    <= '0;
      count_reg   <= '0;
      done_reg    <= 1'b0;
      dropped_reg <= 1'b0;
      for (int i = 0; i < DEPTH; i++) snap_reg[i] <= '0;
    end else begin
      done_reg    <= 1'b0;
      dropped_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (capture) begin
            for (int i = 0; i < DEPTH; i++) snap_reg[i] <= slot_in[i];
            mask_reg  <= cap_mask;
            count_reg <= '0;
            if (|cap_mask) state_reg <= DRAIN;
            else           done_reg  <= 1'b1;
          end
        end
        DRAIN: begin
          dropped_reg <= capture;
          if (handshake && count_reg != CW'(DEPTH))
            count_reg <= count_reg + 1'b1;
          // Flush overrides completion: a final handshake alongside flush gives no done.
          if (flush) begin
            state_reg <= IDLE;
            mask_reg  <= '0;
          end else if (handshake) begin
            mask_reg <= mask_next;
            if (mask_next == '0) begin
              state_reg <= IDLE;
              done_reg  <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_movegen_stack_reader.sv
// Directed self-checking bench for movegen_stack_reader (DEPTH=16, WIDTH=10).
module tb_movegen_stack_reader;

  localparam int DEPTH = 16;
  localparam int WIDTH = 10;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   capture;
  logic [DEPTH*WIDTH-1:0] in_slots;
  logic                   flush;
  logic [WIDTH-1:0]       out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;
  logic                   done;
  logic [CW-1:0]          count;
  logic                   dropped;

  int checks   = 0;
  int failures = 0;

  movegen_stack_reader #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .capture   (capture),
    .in_slots  (in_slots),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .dropped   (dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_basic();
    in_slots = '0;
    in_slots[0*WIDTH +: WIDTH] = 10'h005;
    in_slots[3*WIDTH +: WIDTH] = 10'h1A2;
    in_slots[7*WIDTH +: WIDTH] = 10'h3FF;
  endtask

  task automatic do_capture();
    capture = 1'b1;
    tick();
    capture = 1'b0;
  endtask

  logic [WIDTH-1:0] basic_exp [3] = '{10'h005, 10'h1A2, 10'h3FF};
  logic             ready_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int idx;
    rst = 1'b1; capture = 1'b0; flush = 1'b0; out_ready = 1'b0; in_slots = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_valid",   32'(out_valid), 32'd0);
    chk("reset_data",    32'(out_data),  32'd0);
    chk("reset_busy",    32'(busy),      32'd0);
    chk("reset_done",    32'(done),      32'd0);
    chk("reset_count",   32'(count),     32'd0);
    chk("reset_dropped", 32'(dropped),   32'd0);

    // Full-throughput drain of three sparse entries.
    load_basic();
    out_ready = 1'b1;
    do_capture();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("basic_valid%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("basic_data%0d", i),  32'(out_data),  32'(basic_exp[i]));
      tick();
    end
    chk("basic_done",  32'(done),      32'd1);
    chk("basic_count", 32'(count),     32'd3);
    chk("basic_busy",  32'(busy),      32'd0);
    chk("basic_valid_end", 32'(out_valid), 32'd0);
    chk("basic_data_idle", 32'(out_data),  32'd0);
    tick();
    chk("basic_done_pulse", 32'(done), 32'd0);

    // Backpressure: data must hold through stalls.
    out_ready = 1'b0;
    do_capture();
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      out_ready = ready_pat[i];
      chk($sformatf("stall_data%0d", i), 32'(out_data), 32'(basic_exp[idx]));
      tick();
      if (ready_pat[i]) idx++;
    end
    chk("stall_done",  32'(done),  32'd1);
    chk("stall_count", 32'(count), 32'd3);
    chk("stall_valid", 32'(out_valid), 32'd0);

    // Empty snapshot completes immediately without a drain.
    out_ready = 1'b1;
    in_slots = '0;
    do_capture();
    chk("empty_done",  32'(done),      32'd1);
    chk("empty_valid", 32'(out_valid), 32'd0);
    chk("empty_busy",  32'(busy),      32'd0);
    chk("empty_count", 32'(count),     32'd0);
    tick();
    chk("empty_done_pulse", 32'(done), 32'd0);

    // Capture while busy is dropped and the drain carries on.
    load_basic();
    do_capture();
    tick();
    chk("drop_pre_data", 32'(out_data), 32'h1A2);
    for (int i = 0; i < DEPTH; i++) in_slots[i*WIDTH +: WIDTH] = 10'h2AA;
    do_capture();
    chk("drop_pulse", 32'(dropped),  32'd1);
    chk("drop_data",  32'(out_data), 32'h3FF);
    tick();
    chk("drop_pulse_end", 32'(dropped), 32'd0);
    chk("drop_done",      32'(done),    32'd1);
    chk("drop_count",     32'(count),   32'd3);
    chk("drop_valid",     32'(out_valid), 32'd0);

    // Flush after two of five entries accepted.
    in_slots = '0;
    in_slots[1*WIDTH +: WIDTH]  = 10'h011;
    in_slots[2*WIDTH +: WIDTH]  = 10'h022;
    in_slots[5*WIDTH +: WIDTH]  = 10'h055;
    in_slots[9*WIDTH +: WIDTH]  = 10'h099;
    in_slots[15*WIDTH +: WIDTH] = 10'h0FF;
    do_capture();
    chk("flush_first", 32'(out_data), 32'h011);
    tick();
    chk("flush_second", 32'(out_data), 32'h022);
    tick();
    chk("flush_third", 32'(out_data), 32'h055);
    out_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_busy",  32'(busy),      32'd0);
    chk("flush_done",  32'(done),      32'd0);
    chk("flush_count", 32'(count),     32'd2);
    tick();
    chk("flush_no_late_done", 32'(done), 32'd0);
    load_basic();
    out_ready = 1'b1;
    do_capture();
    chk("reload_count", 32'(count),    32'd0);
    chk("reload_data",  32'(out_data), 32'h005);
    tick(); tick(); tick();
    chk("reload_done",  32'(done),  32'd1);
    chk("reload_count_end", 32'(count), 32'd3);

    // Reset mid-drain with ready low.
    out_ready = 1'b0;
    do_capture();
    chk("rstmid_valid_pre", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_valid", 32'(out_valid), 32'd0);
    chk("rstmid_data",  32'(out_data),  32'd0);
    chk("rstmid_busy",  32'(busy),      32'd0);
    chk("rstmid_done",  32'(done),      32'd0);
    chk("rstmid_count", 32'(count),     32'd0);

    // Every slot occupied: 16 back-to-back entries.
    for (int i = 0; i < DEPTH; i++) in_slots[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
    out_ready = 1'b1;
    do_capture();
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("full_data%0d", i), 32'(out_data), 32'(i + 1));
      tick();
    end
    chk("full_done",  32'(done),  32'd1);
    chk("full_count", 32'(count), 32'd16);
    chk("full_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/movegen_stack_reader.md
Name: movegen_stack_reader

Overview:
- Read-side counterpart of the move-generator piece stack.
- The stack holds DEPTH register slots; an empty slot reads as all-zero.
- On a capture strobe, the block snapshots every slot in parallel, then emits the non-zero entries one per cycle to the downstream search/evaluation logic over a valid/ready handshake.
- Empty slots are skipped with no bubble cycles.

Parameters:
- DEPTH, 16, number of stack slots snapshotted (1..64).
- WIDTH, 10, bits per slot entry (move/piece encoding; all-zero = empty).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- capture  input  1  single-cycle strobe: snapshot in_slots and start draining.
- in_slots  input  DEPTH*WIDTH  flattened stack contents; slot i = in_slots[i*WIDTH +: WIDTH]; slot 0 is the top of stack.
- flush  input  1  abort the current drain and return to IDLE.
- out_data  output  WIDTH  current entry.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data this cycle.
- busy  output  1  high while in DRAIN.
- done  output  1  one-cycle pulse when a drain completes normally.
- count  output  $clog2(DEPTH+1)  number of entries emitted in the current/last drain.
- dropped  output  1  one-cycle pulse when capture arrives while busy.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; snapshot registers=0; occupancy mask=0.
  - out_valid=0, out_data=0, busy=0, done=0, count=0, dropped=0.
  - rst has priority over all other inputs and is honoured mid-drain.
- State IDLE:
  - capture=1 at edge N: latch every slot into snapshot regs; mask[i] = (slot i != 0); count=0.
  - If the mask is non-zero: go to DRAIN; busy=1 and out_valid=1 from cycle N+1.
  - If the mask is all-zero: stay IDLE; done=1 at N+1 only.
  - Latency from capture to first out_valid is exactly 1 cycle.
- State DRAIN:
  - out_data = snapshot[f], where f is the lowest set index of the mask (top of stack first).
  - out_valid = 1 for the whole state.
  - out_data must stay stable while out_valid && !out_ready.
  - On out_valid && out_ready: clear mask[f]; count += 1. The next entry is presented the following cycle (full throughput, one per cycle with ready held high).
  - When the accepted entry was the last set bit: go to IDLE; out_valid=0 and busy=0 next cycle; done=1 for exactly that cycle.
  - out_data returns to 0 in IDLE.
- Simultaneous events:
  - capture while busy (DRAIN): the new snapshot is ignored and dropped pulses for 1 cycle. The drain in progress is unaffected.
  - flush in DRAIN: go to IDLE next cycle; mask cleared; out_valid=0; no done pulse; count holds its value. A handshake in the same cycle as flush still counts.
  - flush in IDLE: no effect.
  - capture and flush together in IDLE: capture wins.
  - capture and flush together in DRAIN: flush wins and dropped pulses.
- count saturates at DEPTH; by construction it cannot exceed DEPTH.
- Non-zero entries are emitted in ascending slot index; order is preserved exactly. Zero-valued slots are never emitted.

Decomposition:
- Shared package movegen_pkg holds:
  - MOVE_W localparam (=10);
  - typedef move_t (logic [MOVE_W-1:0]);
  - constant MOVE_NONE = '0;
  - typedef drain_state_t enum {IDLE, DRAIN}.
- One natural sub-module, movegen_find_first:
  - parameterised DEPTH;
  - purely combinational lowest-set-bit finder;
  - outputs index (clog2 width) and any (mask non-zero).
- It is reused by other movegen drains.

Test Plan:
- Reset, then capture with slots {0:0x005, 3:0x1A2, 7:0x3FF}, rest 0, and out_ready held 1:
  - out_valid rises 1 cycle after capture;
  - emits 0x005, 0x1A2, 0x3FF on three consecutive cycles;
  - done pulses with count=3; busy falls.
- Same load, with out_ready toggling 1,0,0,1,0,1: out_data holds 0x1A2 across the stall cycles; the sequence and count=3 are unchanged.
- Capture with all slots zero: done=1 one cycle later; out_valid and busy never assert; count=0.
- During a drain (after 1 entry accepted), pulse capture with different data: dropped pulses once; the remaining original entries are emitted; the new data is never seen.
- Assert flush after 2 of 5 entries are accepted: out_valid=0 next cycle; no done; count=2; a new capture afterwards drains normally from slot 0.
- Assert rst mid-drain with out_ready=0: all outputs are 0 next cycle. DEPTH=16 with all slots non-zero (0x001..0x010) after reset emits 16 entries back-to-back, and count=16.
